// File: rtl/snn_spike_sequencer.sv
// snn_spike_sequencer: runs one SNN inference from clear to result.
// Clears neurons, replays the rank-ordered input list over a 4-phase
// AER port, auto-acks core output spikes and keeps the first one.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start               1-cycle pulse, accepted only when idle
//   cfg_num_spikes      number of entries to issue (clamped to N_IN)
//   cfg_timeout         wait budget after the last input event
//   rank_rd_en/addr     image-buffer read strobe and address
//   rank_rd_data        buffer data, valid the cycle after the strobe
//   neur_clr            1-cycle membrane clear pulse
//   sched_full          core scheduler full, holds back a new request
//   aer_in_addr/req/ack input event port (4-phase)
//   aer_out_addr/req/ack output spike port (auto-acknowledged)
//   busy, done          run status, end-of-run pulse
//   result_label        neuron of the first output spike
//   result_timeout      no output spike seen before timeout
//   spike_count         input events completed this run
module snn_spike_sequencer #(
    parameter int N_IN = 256,
    parameter int AW   = 8,
    parameter int CW   = 9,
    parameter int TW   = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [CW-1:0] cfg_num_spikes,
    input  logic [TW-1:0] cfg_timeout,
    output logic          rank_rd_en,
    output logic [AW-1:0] rank_rd_addr,
    input  logic [AW-1:0] rank_rd_data,
    output logic          neur_clr,
    input  logic          sched_full,
    output logic [AW-1:0] aer_in_addr,
    output logic          aer_in_req,
    input  logic          aer_in_ack,
    input  logic [AW-1:0] aer_out_addr,
    input  logic          aer_out_req,
    output logic          aer_out_ack,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] result_label,
    output logic          result_timeout,
    output logic [CW-1:0] spike_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_LOAD,
        S_REQ,
        S_RELEASE,
        S_WAIT_OUT,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] N_MAX = CW'(N_IN);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] num_q;
    logic [TW-1:0] wait_cnt;
    logic          latch_q;
    logic          req_q;
    logic          in_run;
    logic          capture;
    logic          latch_nx;
    logic [CW-1:0] count_inc;

    // Spikes only count while a run is between CLEAR and WAIT_OUT.
    assign in_run    = (state != S_IDLE) && (state != S_DONE);
    assign capture   = aer_out_req && !aer_out_ack && !latch_q && in_run;
    // A spike landing this cycle must steer the decision this cycle.
    assign latch_nx  = latch_q | capture;
    assign count_inc = spike_count + 1'b1;
    assign aer_in_req = req_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                state_nx = (num_q != '0) ? S_FETCH : S_WAIT_OUT;
            end
            S_FETCH: begin
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                if (req_q && aer_in_ack) state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                if (!aer_in_ack) begin
                    if (latch_nx)               state_nx = S_DONE;
                    else if (count_inc < num_q) state_nx = S_FETCH;
                    else                        state_nx = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT: begin
                if (latch_nx || (wait_cnt == cfg_timeout)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        neur_clr     = (state == S_CLEAR);
        rank_rd_en   = (state == S_FETCH);
        rank_rd_addr = (state == S_FETCH) ? AW'(spike_count) : '0;
        busy         = in_run;
        done         = (state == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            num_q          <= '0;
            wait_cnt       <= '0;
            latch_q        <= 1'b0;
            req_q          <= 1'b0;
            aer_in_addr    <= '0;
            aer_out_ack    <= 1'b0;
            result_label   <= '0;
            result_timeout <= 1'b0;
            spike_count    <= '0;
        end else begin
            // Output port ack simply follows the request one cycle late.
            aer_out_ack <= aer_out_req;

            if (capture) begin
                result_label <= aer_out_addr;
                latch_q      <= 1'b1;
            end

            if (state == S_WAIT_OUT) wait_cnt <= wait_cnt + 1'b1;
            else                     wait_cnt <= '0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        spike_count    <= '0;
                        result_label   <= '0;
                        result_timeout <= 1'b0;
                        latch_q        <= 1'b0;
                        num_q <= (cfg_num_spikes > N_MAX) ?
                                 N_MAX : cfg_num_spikes;
                    end
                end
                S_LOAD: begin
                    aer_in_addr <= rank_rd_data;
                    req_q       <= !sched_full;
                end
                S_REQ: begin
                    // Once raised, the request ignores sched_full.
                    if (!req_q && !sched_full) begin
                        req_q <= 1'b1;
                    end else if (req_q && aer_in_ack) begin
                        req_q <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!aer_in_ack) spike_count <= count_inc;
                end
                S_WAIT_OUT: begin
                    if (!latch_nx && (wait_cnt == cfg_timeout)) begin
                        result_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_spike_sequencer.sv
// Bench for snn_spike_sequencer: directed scenarios plus random runs,
// expected events and results queued at issue time, checked by a monitor.
module tb_snn_spike_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [8:0] cfg_num_spikes = '0;
    logic [15:0] cfg_timeout = '0;
    logic       rank_rd_en;
    logic [7:0] rank_rd_addr;
    logic [7:0] rank_rd_data = '0;
    logic       neur_clr;
    logic       sched_full = 1'b0;
    logic [7:0] aer_in_addr;
    logic       aer_in_req;
    logic       aer_in_ack = 1'b0;
    logic [7:0] aer_out_addr = '0;
    logic       aer_out_req = 1'b0;
    logic       aer_out_ack;
    logic       busy;
    logic       done;
    logic [7:0] result_label;
    logic       result_timeout;
    logic [8:0] spike_count;

    typedef struct {
        logic [7:0] label;
        logic       to;
        int         count;
        int         reads;
    } exp_t;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mem [256];
    exp_t       exp_res [$];
    logic [7:0] exp_addr [$];
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    time        last_fall_t = 0;
    int         ack_dly = 0;
    bit         full_rand = 1'b0;
    bit         full_force = 1'b0;
    int         spike_seq = 0;
    logic [7:0] spike_addr = '0;

    always #5 CLK = ~CLK;

    snn_spike_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start),
        .cfg_num_spikes(cfg_num_spikes), .cfg_timeout(cfg_timeout),
        .rank_rd_en(rank_rd_en), .rank_rd_addr(rank_rd_addr),
        .rank_rd_data(rank_rd_data), .neur_clr(neur_clr),
        .sched_full(sched_full), .aer_in_addr(aer_in_addr),
        .aer_in_req(aer_in_req), .aer_in_ack(aer_in_ack),
        .aer_out_addr(aer_out_addr), .aer_out_req(aer_out_req),
        .aer_out_ack(aer_out_ack), .busy(busy), .done(done),
        .result_label(result_label), .result_timeout(result_timeout),
        .spike_count(spike_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met within cycle budget", name);
    endtask

    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    // Synchronous image buffer: data appears only the cycle after a read.
    initial begin
        bit         pend;
        logic [7:0] a;
        pend = 0;
        a = '0;
        forever begin
            @(negedge CLK);
            if (pend) begin
                rank_rd_data = mem[a];
                pend = 0;
            end else begin
                rank_rd_data = 8'($urandom);
            end
            if (rank_rd_en) begin
                pend = 1;
                a = rank_rd_addr;
            end
        end
    end

    // Input-port responder with a programmable ack delay.
    initial begin
        int dcnt;
        dcnt = 0;
        forever begin
            @(negedge CLK);
            if (aer_in_req && !aer_in_ack) begin
                if (dcnt >= ack_dly) begin
                    aer_in_ack = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else if (!aer_in_req && aer_in_ack) begin
                aer_in_ack = 1'b0;
                fall_cnt++;
                last_fall_t = $time;
            end else begin
                dcnt = 0;
            end
        end
    end

    // Output-spike source; also checks the one-cycle auto-ack timing.
    initial begin
        int served;
        bit cr;
        bit cf;
        served = 0;
        cr = 0;
        cf = 0;
        forever begin
            @(negedge CLK);
            #1;
            if (cr) chk("out_ack_rise", aer_out_ack, 1);
            if (cf) chk("out_ack_fall", aer_out_ack, 0);
            cr = 0;
            cf = 0;
            if (aer_out_req && aer_out_ack) begin
                aer_out_req = 1'b0;
                cf = 1;
            end else if (!aer_out_req && !aer_out_ack &&
                         served != spike_seq) begin
                aer_out_addr = spike_addr;
                aer_out_req = 1'b1;
                served = spike_seq;
                cr = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            #3;
            sched_full = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event or result.
    initial begin
        logic prev_req;
        int   rd_seen;
        exp_t e;
        prev_req = 1'b0;
        rd_seen = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_req = 1'b0;
                rd_seen = 0;
            end else begin
                if (rank_rd_en) rd_seen++;
                if (aer_in_req && !prev_req) begin
                    rise_cnt++;
                    if (exp_addr.size() == 0) fail_now("unexpected_event");
                    else chk("aer_in_addr", aer_in_addr, exp_addr.pop_front());
                end
                prev_req = aer_in_req;
                if (done) begin
                    if (exp_res.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = exp_res.pop_front();
                        chk("result_label", result_label, e.label);
                        chk("result_timeout", result_timeout, e.to);
                        chk("spike_count", spike_count, e.count);
                        chk("rank_reads", rd_seen, e.reads);
                        chk("busy_at_done", busy, 0);
                    end
                    rd_seen = 0;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // Reference model: events issued and result from the run's rules.
    // mode 0 = no spike, 1 = spike after inputs, 2 = spike during event idx.
    task automatic expect_run(input int n_cfg, input int mode, input int idx,
                              input logic [7:0] lab, output int cnt);
        int   n;
        exp_t e;
        n = (n_cfg > 256) ? 256 : n_cfg;
        cnt = n;
        if (mode == 2 && idx < n) cnt = idx + 1;
        for (int i = 0; i < cnt; i++) exp_addr.push_back(mem[i]);
        e.label = (mode == 0) ? 8'd0 : lab;
        e.to = (mode == 0);
        e.count = cnt;
        e.reads = cnt;
        exp_res.push_back(e);
    endtask

    task automatic do_start(input int n, input int to);
        cfg_num_spikes = 9'(n);
        cfg_timeout = 16'(to);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output time t);
        int b;
        b = 0;
        while (!done && b < 20000) begin
            tick();
            b++;
        end
        if (b >= 20000) fail_now("wait_done");
        t = $time;
    endtask

    task automatic settle();
        int b;
        b = 0;
        while ((aer_out_req || aer_out_ack || aer_in_ack || busy || done) &&
               b < 100) begin
            tick();
            b++;
        end
        if (b >= 100) fail_now("settle");
        repeat (2) tick();
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctrl"}, {25'd0, rank_rd_en, neur_clr, aer_in_req,
            aer_out_ack, busy, done, result_timeout}, 0);
        chk({tag, "_data"}, {8'd0, rank_rd_addr, aer_in_addr,
            result_label}, 0);
        chk({tag, "_count"}, 32'(spike_count), 0);
    endtask

    task automatic run_one(input int n_cfg, input int mode, input int idx,
                           input logic [7:0] lab, input int to, input int k,
                           input bit lat, output time t_done);
        int cnt;
        int base_r;
        int base_f;
        int b;
        expect_run(n_cfg, mode, idx, lab, cnt);
        base_r = rise_cnt;
        base_f = fall_cnt;
        do_start(n_cfg, to);
        if (lat) begin
            chk("lat_neur_clr_t1", neur_clr, 1);
            tick();
            chk("lat_rd_en_t2", rank_rd_en, 1);
            chk("lat_rd_addr_t2", rank_rd_addr, 0);
            tick();
            chk("lat_req_t3", aer_in_req, 0);
            tick();
            chk("lat_req_t4", aer_in_req, 1);
        end
        b = 0;
        if (mode == 2) begin
            while (rise_cnt < base_r + idx + 1 && b < 20000) begin
                tick();
                b++;
            end
            if (b >= 20000) fail_now("wait_event");
            spike_addr = lab;
            spike_seq++;
        end else if (mode == 1) begin
            while (fall_cnt < base_f + cnt && b < 20000) begin
                tick();
                b++;
            end
            if (b >= 20000) fail_now("wait_last_release");
            repeat (k) tick();
            spike_addr = lab;
            spike_seq++;
        end
        wait_done(t_done);
        settle();
    endtask

    initial begin
        time t_d;
        int  cnt;
        int  hi;
        int  b;
        int  n;
        int  mode;

        RST = 1'b1;
        repeat (3) tick();
        chk_outs_zero("reset");
        RST = 1'b0;
        tick();

        mem[0] = 8'd5;
        mem[1] = 8'd17;
        mem[2] = 8'd200;
        ack_dly = 2;
        run_one(3, 1, 0, 8'd7, 100, 10, 1, t_d);

        // Spike while idle is acked but must not disturb the results.
        spike_addr = 8'd99;
        spike_seq++;
        repeat (6) tick();
        chk("idle_label", result_label, 7);
        chk("idle_timeout", result_timeout, 0);
        chk("idle_count", spike_count, 3);

        fill_mem();
        ack_dly = 1;
        run_one(4, 0, 0, 8'd0, 20, 0, 0, t_d);
        chk("timeout_gap", 32'(t_d - last_fall_t), 222);

        fill_mem();
        ack_dly = 2;
        run_one(256, 2, 10, 8'd3, 100, 0, 0, t_d);

        fill_mem();
        ack_dly = 0;
        run_one(3, 2, 2, 8'd42, 100, 0, 0, t_d);

        fill_mem();
        ack_dly = 1;
        expect_run(2, 0, 0, 8'd0, cnt);
        do_start(2, 3);
        tick();
        tick();
        full_force = 1'b1;
        hi = 0;
        for (int i = 0; i < 29; i++) begin
            tick();
            if (aer_in_req) hi++;
            start = (i == 5);
        end
        start = 1'b0;
        chk("req_while_full", hi, 0);
        chk("busy_while_full", busy, 1);
        full_force = 1'b0;
        wait_done(t_d);
        settle();

        expect_run(0, 0, 0, 8'd0, cnt);
        do_start(0, 0);
        chk("n0_clr_t1", neur_clr, 1);
        chk("n0_done_t1", done, 0);
        tick();
        chk("n0_done_t2", done, 0);
        tick();
        chk("n0_done_t3", done, 1);
        settle();

        fill_mem();
        ack_dly = 3;
        expect_run(3, 0, 0, 8'd0, cnt);
        do_start(3, 5);
        b = 0;
        while (!aer_in_req && b < 100) begin
            tick();
            b++;
        end
        if (b >= 100) fail_now("wait_req_before_rst");
        RST = 1'b1;
        tick();
        chk_outs_zero("rst_mid");
        RST = 1'b0;
        exp_addr.delete();
        exp_res.delete();
        repeat (4) tick();

        fill_mem();
        ack_dly = 1;
        run_one(2, 1, 0, 8'($urandom), 40, 3, 1, t_d);

        fill_mem();
        full_rand = 1'b1;
        ack_dly = 0;
        run_one(511, 0, 0, 8'd0, 5, 0, 0, t_d);

        for (int r = 0; r < 10; r++) begin
            fill_mem();
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            ack_dly = $urandom_range(0, 3);
            run_one(n, mode, $urandom_range(0, n - 1), 8'($urandom),
                    (mode == 0) ? $urandom_range(0, 15) :
                                  $urandom_range(30, 60),
                    $urandom_range(1, 10), 0, t_d);
        end
        full_rand = 1'b0;

        chk("leftover_events", exp_addr.size(), 0);
        chk("leftover_results", exp_res.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_spike_sequencer.md
Name: snn_spike_sequencer

Overview:
- Sequences one inference on the SNN core.
- Clears neuron state, then reads a rank-ordered list of input-neuron addresses from the image buffer.
- Issues each address to the core input AER port with a 4-phase req/ack handshake.
- Auto-acknowledges the core output AER port and latches the first output spike as the classification result, or reports a timeout.
- Sits between the AXI-lite register block (start/config/result) and the SNN core/scheduler.

Parameters:
- N_IN, 256, max rank-order entries; buffer depth.
- AW, 8, address width of input neuron, output neuron and buffer address.
- CW, 9, width of spike-count fields; must satisfy 2^CW > N_IN.
- TW, 16, width of the timeout counter.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  1-cycle pulse; begins inference when idle
- cfg_num_spikes  in  CW  entries to issue; values above N_IN are clamped to N_IN
- cfg_timeout  in  TW  cycles to wait for an output spike after the last input event
- rank_rd_en  out  1  buffer read strobe
- rank_rd_addr  out  AW  buffer read address
- rank_rd_data  in  AW  buffer data, valid the cycle after rank_rd_en
- neur_clr  out  1  1-cycle pulse clearing membrane potentials
- sched_full  in  1  core scheduler full; blocks a new aer_in_req
- aer_in_addr  out  AW  input event address
- aer_in_req  out  1  input event request
- aer_in_ack  in  1  input event acknowledge, synchronous to CLK
- aer_out_addr  in  AW  output spike neuron address
- aer_out_req  in  1  output spike request, synchronous to CLK
- aer_out_ack  out  1  output spike acknowledge
- busy  out  1  high from the cycle after start until DONE
- done  out  1  1-cycle pulse at end of inference
- result_label  out  AW  first output-spike neuron
- result_timeout  out  1  1 = no output spike seen
- spike_count  out  CW  input events completed this inference

Behaviour:
- Reset: every output is 0, state IDLE, and the first-spike latch is cleared.
  - A synchronous RST mid-handshake drops aer_in_req and aer_out_ack on the next edge; no completion is required.
- States:
  - IDLE: start → CLEAR, and spike_count, result_label, result_timeout and the latch are cleared. A start pulse while busy is ignored.
  - CLEAR: neur_clr=1 for exactly one cycle. Go to FETCH if N>0, else WAIT_OUT. N is cfg_num_spikes sampled at start and clamped.
  - FETCH: rank_rd_en=1, rank_rd_addr=spike_count → LOAD.
  - LOAD: aer_in_addr <= rank_rd_data → REQ.
  - REQ: aer_in_req=1 only when sched_full=0 at entry; it then holds regardless of sched_full. Stay until aer_in_ack=1 → RELEASE.
  - RELEASE: aer_in_req=0. Stay until aer_in_ack=0, then spike_count+1. Next state:
    - DONE if the latch is set;
    - else FETCH if the new count < N;
    - else WAIT_OUT.
  - WAIT_OUT: counter increments each cycle. Go to DONE when the latch is set, or when counter == cfg_timeout (result_timeout=1). cfg_timeout=0 → timeout on the first WAIT_OUT cycle unless the latch is already set.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency: start sampled at edge t.
  - neur_clr high in cycle t+1.
  - rank_rd_en in t+2.
  - First aer_in_req in t+4 at the earliest.
  - Each subsequent event takes a minimum of 4 cycles plus handshake wait.
- Output AER auto-ack runs in every state:
  - aer_out_ack rises the cycle after aer_out_req is seen high.
  - aer_out_ack falls the cycle after aer_out_req is seen low.
- First spike: captured on the cycle aer_out_ack rises, in any state from CLEAR through WAIT_OUT, if the latch is clear.
  - result_label <= aer_out_addr and the latch is set.
  - Later spikes are acked and ignored.
  - Spikes in IDLE/DONE are acked and not recorded.
- Abort: when the latch is set during FETCH/LOAD/REQ, the in-flight handshake completes. The current address is still issued, then RELEASE → DONE; no further reads.
- A spike and the completion of the final RELEASE in the same cycle → DONE with result_timeout=0.
- result_label, result_timeout and spike_count hold their values until the next accepted start.

Test Plan:
- N=3, buffer {5,17,200}, ack responder with 2-cycle delay, output spike addr 7 in WAIT_OUT after 10 cycles, timeout 100 → aer_in_addr 5,17,200 in order; done, result_label=7, result_timeout=0, spike_count=3.
- N=4, no output spike, cfg_timeout=20 → done exactly 21 cycles after the final RELEASE exit; result_timeout=1, spike_count=4.
- N=256, output spike addr 3 asserted while event index 10 is in REQ → event 10 handshake completes; spike_count=11, result_label=3, no rank_rd_en afterwards.
- sched_full held high for 30 cycles from t+3 → aer_in_req stays low until sched_full drops, then proceeds; start pulse while busy ignored.
- N=0, cfg_timeout=0 → neur_clr pulse then done at t+3; result_timeout=1, spike_count=0.
- RST asserted while aer_in_req=1 → next cycle all outputs 0, state IDLE; a fresh start runs normally.
